ps2_dir_ctrl: RTL and testbench

- Sequences decoded PS/2 scan-code bytes from the keyboard front end into a game direction command.
- Decodes Set-2 make/break and E0-extended sequences, and tracks held state of four direction keys (arrows and WASD).
- Arbitrates simultaneous holds, most recent press wins.
- Schedules the step pulses that drive the movement logic: one on press, then a hold delay, then periodic repeats.
- Sits between the PS/2 byte receiver and the game core, replacing direct use of the raw move/kb_out path.

---
 rtl/ps2_dir_ctrl.sv | 88 ++++++++
 tb/tb_ps2_dir_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dir_ctrl.sv
// ps2_dir_ctrl: turns PS/2 Set-2 scan-code bytes into a held-key mask, an arbitrated
// direction and press/hold/repeat step pulses.
//   clk      system clock
//   clr      asynchronous active-high reset
//   rx_data  received scan-code byte, valid when rx_valid is high
//   rx_valid one-cycle byte strobe
//   held     held mask: bit0 up, bit1 down, bit2 left, bit3 right
//   move     one-hot active direction (same order), 0 = none
//   kb_out   active direction code: 0 none, 1 up, 2 down, 3 left, 4 right
//   step     one-cycle pulse commanding a movement step toward kb_out
module ps2_dir_ctrl #(
    parameter int             CW            = 21,
    parameter logic [CW-1:0]  HOLD_DELAY    = 21'd2000000,
    parameter logic [CW-1:0]  REPEAT_PERIOD = 21'd1000000,
    parameter logic [CW-1:0]  PFX_TIMEOUT   = 21'd100000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] held,
    output logic [3:0] move,
    output logic [2:0] kb_out,
    output logic       step
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    state_t        state, state_nxt;
    logic [CW-1:0] pfx_cnt, pfx_nxt, rep_cnt, rep_nxt, lim;
    logic          phase, phase_nxt, step_nxt;
    logic          is_e0, is_f0, is_key, ext, brk, start, hit;
    logic [3:0]    key, held_nxt, pri, act_nxt;
    logic [2:0]    kb_nxt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            pfx_cnt <= '0;
            rep_cnt <= '0;
            phase   <= 1'b0;
            held    <= 4'b0;
            move    <= 4'b0;
            kb_out  <= 3'd0;
            step    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pfx_cnt <= pfx_nxt;
            rep_cnt <= rep_nxt;
            phase   <= phase_nxt;
            held    <= held_nxt;
            move    <= act_nxt;
            kb_out  <= kb_nxt;
            step    <= step_nxt;
        end
    end

    always_comb begin
        is_e0  = rx_valid && rx_data == 8'hE0;
        is_f0  = rx_valid && rx_data == 8'hF0;
        is_key = rx_valid && !is_e0 && !is_f0;
        ext    = state == EXT || state == EXT_BRK;
        brk    = state == BRK || state == EXT_BRK;
        key    = !is_key ? 4'b0000 :
                 ext ? (rx_data == 8'h75 ? 4'b0001 : rx_data == 8'h72 ? 4'b0010 :
                        rx_data == 8'h6B ? 4'b0100 : rx_data == 8'h74 ? 4'b1000 : 4'b0000) :
                       (rx_data == 8'h1D ? 4'b0001 : rx_data == 8'h1B ? 4'b0010 :
                        rx_data == 8'h1C ? 4'b0100 : rx_data == 8'h23 ? 4'b1000 : 4'b0000);
        held_nxt  = brk ? held & ~key : held | key;
        pri       = held_nxt[0] ? 4'b0001 : held_nxt[1] ? 4'b0010 :
                    held_nxt[2] ? 4'b0100 : held_nxt[3] ? 4'b1000 : 4'b0000;
        // A fresh make takes over; losing the active key falls back by fixed priority.
        act_nxt   = (!brk && key != 4'b0 && key != move) ? key :
                    (brk && (key & held & move) != 4'b0) ? pri : move;
        kb_nxt    = act_nxt[0] ? 3'd1 : act_nxt[1] ? 3'd2 : act_nxt[2] ? 3'd3 :
                    act_nxt[3] ? 3'd4 : 3'd0;
        state_nxt = is_e0 ? EXT :
                    is_f0 ? (state == IDLE ? BRK : state == EXT ? EXT_BRK : state) :
                    is_key ? IDLE :
                    (state != IDLE && pfx_cnt == PFX_TIMEOUT - 1'b1) ? IDLE : state;
        pfx_nxt   = (rx_valid || state == IDLE || pfx_cnt == PFX_TIMEOUT - 1'b1) ? '0 : pfx_cnt + 1'b1;
        // A direction change outranks a repeat landing on the same cycle.
        lim       = phase ? REPEAT_PERIOD - 1'b1 : HOLD_DELAY - 1'b1;
        start     = act_nxt != move && act_nxt != 4'b0;
        hit       = act_nxt != 4'b0 && rep_cnt == lim;
        step_nxt  = start || hit;
        rep_nxt   = (start || hit || act_nxt == 4'b0) ? '0 : rep_cnt + 1'b1;
        phase_nxt = start ? 1'b0 : hit ? 1'b1 : phase;
    end
endmodule

// File: tb/tb_ps2_dir_ctrl.sv
// tb_ps2_dir_ctrl: directed self-checking bench for ps2_dir_ctrl with short timing parameters.
module tb_ps2_dir_ctrl;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] held, move;
    logic [2:0] kb_out;
    logic       step;
    int         tests = 0;
    int         fails = 0;

    ps2_dir_ctrl #(.CW(21), .HOLD_DELAY(21'd8), .REPEAT_PERIOD(21'd4), .PFX_TIMEOUT(21'd16)) dut (
        .clk(clk), .clr(clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .held(held), .move(move), .kb_out(kb_out), .step(step)
    );

    always #5 clk = ~clk;

    // Entered and left on a falling edge; the byte is sampled by the rising edge in between.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        clr = 1'b1;
        idle(2);
        tests++;
        if ({held, move, kb_out, step} !== 12'b0) begin
            fails++;
            $display("FAIL reset: got %b want %b", {held, move, kb_out, step}, 12'b0);
        end
        clr = 1'b0;
        idle(1);
    endtask

    task automatic test_press_release;
        send(8'hE0);
        send(8'h75);
        tests++;
        if ({held, move, kb_out, step} !== {4'b0001, 4'b0001, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL press_up: got %b want %b", {held, move, kb_out, step}, {4'b0001, 4'b0001, 3'd1, 1'b1});
        end
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            tests++;
            if (step !== (k == 8 || k == 12 || k == 16)) begin
                fails++;
                $display("FAIL hold_sched k=%0d: got %b want %b", k, step, (k == 8 || k == 12 || k == 16));
            end
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        tests++;
        if ({held, move, kb_out, step} !== 12'b0) begin
            fails++;
            $display("FAIL release_up: got %b want %b", {held, move, kb_out, step}, 12'b0);
        end
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            tests++;
            if (step !== 1'b0) begin
                fails++;
                $display("FAIL no_step_after_release k=%0d: got %b want 0", k, step);
            end
        end
    endtask

    task automatic test_preempt;
        send(8'hE0);
        send(8'h75);
        idle(2);
        send(8'h23);
        tests++;
        if ({held, move, kb_out, step} !== {4'b1001, 4'b1000, 3'd4, 1'b1}) begin
            fails++;
            $display("FAIL preempt_right: got %b want %b", {held, move, kb_out, step}, {4'b1001, 4'b1000, 3'd4, 1'b1});
        end
        send(8'hF0);
        send(8'h23);
        tests++;
        if ({held, move, kb_out, step} !== {4'b0001, 4'b0001, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL back_to_up: got %b want %b", {held, move, kb_out, step}, {4'b0001, 4'b0001, 3'd1, 1'b1});
        end
        for (int k = 1; k <= 8; k++) begin
            idle(1);
            tests++;
            if (step !== (k == 8)) begin
                fails++;
                $display("FAIL restart_sched k=%0d: got %b want %b", k, step, (k == 8));
            end
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
    endtask

    task automatic test_fallback;
        send(8'h1D);
        send(8'h1B);
        tests++;
        if ({held, move, kb_out, step} !== {4'b0011, 4'b0010, 3'd2, 1'b1}) begin
            fails++;
            $display("FAIL press_s: got %b want %b", {held, move, kb_out, step}, {4'b0011, 4'b0010, 3'd2, 1'b1});
        end
        send(8'hF0);
        send(8'h1B);
        tests++;
        if ({held, move, kb_out, step} !== {4'b0001, 4'b0001, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL fallback_up: got %b want %b", {held, move, kb_out, step}, {4'b0001, 4'b0001, 3'd1, 1'b1});
        end
        send(8'hF0);
        send(8'h1C);
        tests++;
        if ({held, move, kb_out, step} !== {4'b0001, 4'b0001, 3'd1, 1'b0}) begin
            fails++;
            $display("FAIL break_unheld: got %b want %b", {held, move, kb_out, step}, {4'b0001, 4'b0001, 3'd1, 1'b0});
        end
        send(8'hF0);
        send(8'h1D);
        tests++;
        if ({held, move, kb_out, step} !== 12'b0) begin
            fails++;
            $display("FAIL release_w: got %b want %b", {held, move, kb_out, step}, 12'b0);
        end
    endtask

    task automatic test_typematic;
        send(8'hE0);
        send(8'h6B);
        tests++;
        if ({held, move, kb_out, step} !== {4'b0100, 4'b0100, 3'd3, 1'b1}) begin
            fails++;
            $display("FAIL press_left: got %b want %b", {held, move, kb_out, step}, {4'b0100, 4'b0100, 3'd3, 1'b1});
        end
        // Four more E0 6B pairs, one every 3 cycles, then plain holding.
        for (int k = 1; k <= 20; k++) begin
            rx_valid = k <= 12 && k % 3 != 0;
            rx_data  = k % 3 == 1 ? 8'hE0 : 8'h6B;
            @(negedge clk);
            rx_valid = 1'b0;
            tests++;
            if (step !== (k == 8 || k == 12 || k == 16 || k == 20)) begin
                fails++;
                $display("FAIL typematic k=%0d: got %b want %b", k, step, (k == 8 || k == 12 || k == 16 || k == 20));
            end
        end
        tests++;
        if ({held, kb_out} !== {4'b0100, 3'd3}) begin
            fails++;
            $display("FAIL typematic_held: got %b want %b", {held, kb_out}, {4'b0100, 3'd3});
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h6B);
    endtask

    task automatic test_prefix_timeout;
        send(8'hE0);
        idle(16);
        send(8'h75);
        tests++;
        if ({held, kb_out} !== 7'b0) begin
            fails++;
            $display("FAIL timeout_ignored: got %b want %b", {held, kb_out}, 7'b0);
        end
        send(8'hE0);
        idle(15);
        send(8'h75);
        tests++;
        if ({held, kb_out, step} !== {4'b0001, 3'd1, 1'b1}) begin
            fails++;
            $display("FAIL timeout_edge: got %b want %b", {held, kb_out, step}, {4'b0001, 3'd1, 1'b1});
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        send(8'hF0);
        send(8'hE0);
        send(8'h74);
        tests++;
        if ({held, move, kb_out, step} !== {4'b1000, 4'b1000, 3'd4, 1'b1}) begin
            fails++;
            $display("FAIL f0_then_e0: got %b want %b", {held, move, kb_out, step}, {4'b1000, 4'b1000, 3'd4, 1'b1});
        end
    endtask

    task automatic test_async_clear;
        idle(10);
        send(8'hE0);
        #2 clr = 1'b1;
        #1;
        tests++;
        if ({held, move, kb_out, step} !== 12'b0) begin
            fails++;
            $display("FAIL async_clear: got %b want %b", {held, move, kb_out, step}, 12'b0);
        end
        @(negedge clk);
        clr = 1'b0;
        send(8'h74);
        tests++;
        if ({held, kb_out, step} !== 8'b0) begin
            fails++;
            $display("FAIL prefix_discarded: got %b want %b", {held, kb_out, step}, 8'b0);
        end
        send(8'hE0);
        send(8'h74);
        tests++;
        if ({held, move, kb_out, step} !== {4'b1000, 4'b1000, 3'd4, 1'b1}) begin
            fails++;
            $display("FAIL fresh_press: got %b want %b", {held, move, kb_out, step}, {4'b1000, 4'b1000, 3'd4, 1'b1});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_press_release;
        test_preempt;
        test_fallback;
        test_typematic;
        test_prefix_timeout;
        test_async_clear;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
